// File: rtl/weight_row_updater_if.sv
// Bus between the weight row updater, its delta producer/requester and the weight RAM.
// The master modport is the updater side; the slave modport is the environment.
interface weight_row_updater_if #(
   parameter int WIDTH  = 10,
   parameter int WORDS  = 10,
   parameter int ADDR_W = 5,
   parameter int ROW_W  = 2
);
   logic                    Start;
   logic [ROW_W-1:0]        Row;
   logic signed [WIDTH-1:0] Delta;
   logic                    Delta_Valid;
   logic                    Delta_Ready;
   logic                    Busy;
   logic                    Done;
   logic                    Error;
   logic [ADDR_W-1:0]       Ram_Address;
   logic                    Ram_WE;
   logic signed [WIDTH-1:0] Ram_D [0:WORDS-1];
   logic signed [WIDTH-1:0] Ram_Q [0:WORDS-1];

   modport master (
      input  Start, Row, Delta, Delta_Valid, Ram_Q,
      output Delta_Ready, Busy, Done, Error, Ram_Address, Ram_WE, Ram_D
   );

   modport slave (
      output Start, Row, Delta, Delta_Valid, Ram_Q,
      input  Delta_Ready, Busy, Done, Error, Ram_Address, Ram_WE, Ram_D
   );
endinterface

// File: rtl/weight_row_updater.sv
// Read-modify-write of one weight RAM row: read, add WORDS saturating signed deltas, write back.
// Done 13 edges after Start with deltas streaming; Delta_Valid may stall indefinitely in COLLECT.
module weight_row_updater #(
   parameter int WIDTH  = 10,
   parameter int WORDS  = 10,
   parameter int ROWS   = 3,
   parameter int ADDR_W = 5,
   parameter int ROW_W  = 2
) (
   input logic                  Clock,
   input logic                  Reset_n,
   weight_row_updater_if.master bus
);
   localparam int CNT_W = $clog2(WORDS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
   localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] READ    = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] COLLECT = 3'd3;
   localparam logic [2:0] WRITE   = 3'd4;

   logic [2:0]              state;
   logic [CNT_W-1:0]        counter;
   logic signed [WIDTH-1:0] buffer [0:WORDS-1];
   logic signed [WIDTH:0]   sum_ext;
   logic signed [WIDTH-1:0] sat_word;
   logic                    accept;
   logic                    row_ok;
   logic [ADDR_W-1:0]       row_base;

   assign row_ok   = (32'(bus.Row) < ROWS);
   assign row_base = ADDR_W'(bus.Row) * ADDR_W'(WORDS);
   assign accept   = bus.Delta_Valid & bus.Delta_Ready;
   assign bus.Ram_D = buffer;

   // One guard bit is enough: overflow shows up as the top two bits disagreeing.
   assign sum_ext = $signed({buffer[counter][WIDTH-1], buffer[counter]})
                  + $signed({bus.Delta[WIDTH-1], bus.Delta});

   always_comb begin
      sat_word = sum_ext[WIDTH-1:0];
      if (sum_ext[WIDTH] != sum_ext[WIDTH-1])
         sat_word = sum_ext[WIDTH] ? W_MIN : W_MAX;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state           <= IDLE;
         counter         <= '0;
         bus.Busy        <= 1'b0;
         bus.Done        <= 1'b0;
         bus.Error       <= 1'b0;
         bus.Delta_Ready <= 1'b0;
         bus.Ram_WE      <= 1'b0;
         bus.Ram_Address <= '0;
         for (int i = 0; i < WORDS; i++)
            buffer[i] <= '0;
      end else begin
         bus.Done  <= 1'b0;
         bus.Error <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  if (row_ok) begin
                     state           <= READ;
                     bus.Ram_Address <= row_base;
                     bus.Busy        <= 1'b1;
                  end else begin
                     bus.Error <= 1'b1;
                  end
               end
            end
            READ: state <= WAIT;
            WAIT: begin
               for (int i = 0; i < WORDS; i++)
                  buffer[i] <= bus.Ram_Q[i];
               counter         <= '0;
               bus.Delta_Ready <= 1'b1;
               state           <= COLLECT;
            end
            COLLECT: begin
               if (accept) begin
                  buffer[counter] <= sat_word;
                  if (counter == LAST) begin
                     counter         <= '0;
                     bus.Delta_Ready <= 1'b0;
                     bus.Ram_WE      <= 1'b1;
                     state           <= WRITE;
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
            end
            WRITE: begin
               bus.Ram_WE      <= 1'b0;
               bus.Done        <= 1'b1;
               bus.Busy        <= 1'b0;
               bus.Ram_Address <= '0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_weight_row_updater.sv
// Bench for weight_row_updater: behavioural weight RAM, write-back scoreboard, scenario tasks.
module tb_weight_row_updater;
   localparam int WIDTH  = 10;
   localparam int WORDS  = 10;
   localparam int ROWS   = 3;
   localparam int ADDR_W = 5;
   localparam int NWORDS = 30;

   typedef struct packed {
      logic [ADDR_W-1:0]           addr;
      logic [WORDS-1:0][WIDTH-1:0] w;
   } wr_t;

   logic Clock = 1'b0;
   logic Reset_n;
   always #5 Clock = ~Clock;

   weight_row_updater_if #(.WIDTH(WIDTH), .WORDS(WORDS), .ADDR_W(ADDR_W), .ROW_W(2)) bus ();

   weight_row_updater #(.WIDTH(WIDTH), .WORDS(WORDS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ROW_W(2)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus.master)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc_cnt = 0;
   int start_cyc = 0;
   int we_cnt = 0;
   int acc_cnt = 0;
   int rdy_bad = 0;
   int op_bad = 0;
   logic in_op = 1'b0;
   logic do_init = 1'b0;
   logic [ADDR_W-1:0] cur_base = '0;
   logic [WIDTH-1:0] mem [0:NWORDS-1];
   logic [WIDTH-1:0] dl [0:WORDS-1];
   logic [WIDTH-1:0] snap [0:NWORDS-1];
   wr_t exp_q [$];
   wr_t wr_q [$];
   wr_t mon_wr;

   function automatic logic [WIDTH-1:0] init_val(input int j);
      if (j < 10) return (j % 2 == 0) ? 10'h2AA : 10'h155;
      if (j < 20) return 10'h155;
      return 10'h3E0;
   endfunction

   function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] d);
      int s;
      s = int'($signed(w)) + int'($signed(d));
      if (s > 511) s = 511;
      if (s < -512) s = -512;
      return 10'(s);
   endfunction

   always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;

   // Weight RAM: registered 10-wide read every non-write edge, 10-wide write on WE.
   always @(posedge Clock) begin
      if (do_init) begin
         for (int j = 0; j < NWORDS; j++) mem[j] <= init_val(j);
      end else if (bus.Ram_WE) begin
         for (int i = 0; i < WORDS; i++)
            if (int'(bus.Ram_Address) + i < NWORDS) mem[int'(bus.Ram_Address) + i] <= bus.Ram_D[i];
      end else begin
         for (int i = 0; i < WORDS; i++)
            bus.Ram_Q[i] <= (int'(bus.Ram_Address) + i < NWORDS) ? mem[int'(bus.Ram_Address) + i] : '0;
      end
   end

   always @(negedge Clock) begin
      if (bus.Ram_WE === 1'b1) begin
         we_cnt++;
         mon_wr.addr = bus.Ram_Address;
         for (int i = 0; i < WORDS; i++) mon_wr.w[i] = bus.Ram_D[i];
         wr_q.push_back(mon_wr);
      end
      if (bus.Delta_Valid && bus.Delta_Ready) acc_cnt++;
      if (bus.Delta_Ready && !bus.Busy) rdy_bad++;
      if (in_op && (bus.Busy !== 1'b1 || bus.Ram_Address !== cur_base)) op_bad++;
   end

   task automatic start_op(input logic [1:0] row, input bit push);
      wr_t e;
      e.addr = 5'(int'(row) * WORDS);
      for (int i = 0; i < WORDS; i++) e.w[i] = sat(mem[int'(e.addr) + i], dl[i]);
      if (push) exp_q.push_back(e);
      bus.Row = row;
      bus.Start = 1'b1;
      @(posedge Clock); #1;
      bus.Start = 1'b0;
      start_cyc = cyc_cnt;
      cur_base = e.addr;
      in_op = 1'b1;
   endtask

   // mode 0: Delta_Valid held high; mode 1: Delta_Valid follows 1,0,0,1 repeating
   task automatic feed(input int k0, input int k1, input int mode);
      int k;
      int cyc;
      logic v;
      logic acc;
      k = k0;
      cyc = 0;
      while (k < k1 && cyc < 300) begin
         v = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         bus.Delta_Valid = v;
         bus.Delta = dl[k];
         acc = v & bus.Delta_Ready;
         @(posedge Clock); #1;
         if (acc) k++;
         cyc++;
      end
      bus.Delta_Valid = 1'b0;
      n_cmp++;
      if (k != k1) begin
         n_fail++;
         $display("FAIL feed_accept: accepted up to %0d, required %0d", k, k1);
      end
   endtask

   task automatic wait_done(output int lat);
      int c;
      c = 0;
      while (bus.Done !== 1'b1 && c < 200) begin
         @(posedge Clock); #1;
         c++;
      end
      in_op = 1'b0;
      lat = cyc_cnt - start_cyc;
      n_cmp++;
      if (bus.Done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_timeout: no Done within %0d cycles", c);
      end
   endtask

   task automatic test_reset();
      logic [WORDS-1:0][WIDTH-1:0] d;
      Reset_n = 1'b0;
      bus.Start = 1'b0; bus.Row = '0; bus.Delta = '0; bus.Delta_Valid = 1'b0;
      do_init = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      do_init = 1'b0;
      for (int i = 0; i < WORDS; i++) d[i] = bus.Ram_D[i];
      n_cmp++;
      if ({bus.Busy, bus.Done, bus.Error, bus.Delta_Ready, bus.Ram_WE} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy/done/err/rdy/we = %b, required 00000",
                  {bus.Busy, bus.Done, bus.Error, bus.Delta_Ready, bus.Ram_WE});
      end
      n_cmp++;
      if (bus.Ram_Address !== 5'd0) begin
         n_fail++; $display("FAIL reset_addr: got %0d, required 0", bus.Ram_Address);
      end
      n_cmp++;
      if (d !== '0) begin
         n_fail++; $display("FAIL reset_buffer: Ram_D = %h, required all zero", d);
      end
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      @(posedge Clock); #1;
   endtask

   task automatic test_basic();
      int lat, w0, b0, bad;
      wr_t got, exp;
      for (int k = 0; k < WORDS; k++) dl[k] = 10'd1;
      w0 = we_cnt; b0 = op_bad;
      start_op(2'd0, 1'b1);
      feed(0, WORDS, 0);
      wait_done(lat);
      n_cmp++;
      if (lat != 13) begin n_fail++; $display("FAIL basic_latency: Done at edge %0d, required 13", lat); end
      n_cmp++;
      if (we_cnt - w0 != 1) begin n_fail++; $display("FAIL basic_we_cycles: %0d, required 1", we_cnt - w0); end
      n_cmp++;
      if (op_bad != b0) begin n_fail++; $display("FAIL basic_busy_addr: %0d bad cycles, required 0", op_bad - b0); end
      n_cmp++;
      if (wr_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++; $display("FAIL basic_sb: writes %0d, expected %0d", wr_q.size(), exp_q.size());
      end else begin
         got = wr_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp) begin n_fail++; $display("FAIL basic_sb: got %h, required %h", got, exp); end
      end
      bad = 0;
      for (int i = 0; i < WORDS; i++) if (mem[i] !== ((i % 2 == 0) ? 10'h2AB : 10'h156)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL basic_ram: %0d words wrong, word0=%h word1=%h", bad, mem[0], mem[1]); end
      @(posedge Clock); #1;
      n_cmp++;
      if (bus.Ram_Address !== 5'd0 || bus.Busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_idle: addr %0d busy %b, required 0 0", bus.Ram_Address, bus.Busy);
      end
   endtask

   task automatic test_valid_toggle();
      int lat, a0, b0, bad;
      wr_t got, exp;
      for (int k = 0; k < WORDS; k++) dl[k] = 10'(k);
      a0 = acc_cnt; b0 = op_bad;
      start_op(2'd2, 1'b1);
      feed(0, WORDS, 1);
      wait_done(lat);
      bus.Delta_Valid = 1'b1;
      repeat (6) @(posedge Clock);
      #1;
      bus.Delta_Valid = 1'b0;
      n_cmp++;
      if (acc_cnt - a0 != WORDS) begin n_fail++; $display("FAIL toggle_consumed: %0d deltas, required 10", acc_cnt - a0); end
      n_cmp++;
      if (op_bad != b0) begin n_fail++; $display("FAIL toggle_busy_addr: %0d bad cycles, required 0", op_bad - b0); end
      n_cmp++;
      if (wr_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++; $display("FAIL toggle_sb: writes %0d, expected %0d", wr_q.size(), exp_q.size());
      end else begin
         got = wr_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp || got.addr !== 5'd20) begin n_fail++; $display("FAIL toggle_sb: got %h, required %h", got, exp); end
      end
      bad = 0;
      for (int i = 0; i < WORDS; i++) if (mem[20 + i] !== 10'(32'h3E0 + i)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL toggle_order: %0d words wrong, word9=%h required 3e9", bad, mem[29]); end
   endtask

   task automatic test_saturation();
      int lat, bad;
      wr_t got, exp;
      do_init = 1'b1;
      @(posedge Clock); #1;
      do_init = 1'b0;
      for (int k = 0; k < WORDS; k++) dl[k] = 10'd200;
      start_op(2'd1, 1'b1); feed(0, WORDS, 0); wait_done(lat);
      for (int k = 0; k < WORDS; k++) dl[k] = 10'h200;
      @(posedge Clock); #1;
      start_op(2'd2, 1'b1); feed(0, WORDS, 0); wait_done(lat);
      for (int n = 0; n < 2; n++) begin
         n_cmp++;
         if (wr_q.size() == 0 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL sat_sb%0d: writes %0d, expected %0d", n, wr_q.size(), exp_q.size());
         end else begin
            got = wr_q.pop_front(); exp = exp_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL sat_sb%0d: got %h, required %h", n, got, exp); end
         end
      end
      bad = 0;
      for (int i = 10; i < 20; i++) if (mem[i] !== 10'h1FF) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL sat_pos: %0d words wrong, word10=%h required 1ff", bad, mem[10]); end
      bad = 0;
      for (int i = 20; i < 30; i++) if (mem[i] !== 10'h200) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL sat_neg: %0d words wrong, word20=%h required 200", bad, mem[20]); end
   endtask

   task automatic test_error();
      int w0, bad;
      for (int j = 0; j < NWORDS; j++) snap[j] = mem[j];
      w0 = we_cnt;
      bus.Row = 2'd3; bus.Start = 1'b1;
      @(posedge Clock); #1;
      bus.Start = 1'b0;
      n_cmp++;
      if (bus.Error !== 1'b1 || bus.Busy !== 1'b0) begin
         n_fail++; $display("FAIL error_pulse: err %b busy %b, required 1 0", bus.Error, bus.Busy);
      end
      @(posedge Clock); #1;
      n_cmp++;
      if (bus.Error !== 1'b0) begin n_fail++; $display("FAIL error_width: err %b one cycle later, required 0", bus.Error); end
      repeat (4) @(posedge Clock);
      #1;
      bad = 0;
      for (int j = 0; j < NWORDS; j++) if (mem[j] !== snap[j]) bad++;
      n_cmp++;
      if (we_cnt != w0 || bad != 0 || bus.Busy !== 1'b0) begin
         n_fail++; $display("FAIL error_no_access: we %0d, changed words %0d, busy %b, required 0 0 0", we_cnt - w0, bad, bus.Busy);
      end
   endtask

   task automatic test_abort();
      int lat, w0, bad;
      wr_t got, exp;
      for (int k = 0; k < WORDS; k++) dl[k] = 10'd1;
      for (int j = 0; j < NWORDS; j++) snap[j] = mem[j];
      w0 = we_cnt;
      start_op(2'd0, 1'b0);
      feed(0, 2, 0);
      bus.Row = 2'd1; bus.Start = 1'b1;
      @(posedge Clock); #1;
      bus.Start = 1'b0;
      n_cmp++;
      if (bus.Busy !== 1'b1 || bus.Ram_Address !== 5'd0 || bus.Error !== 1'b0) begin
         n_fail++; $display("FAIL abort_start_ignored: busy %b addr %0d err %b, required 1 0 0", bus.Busy, bus.Ram_Address, bus.Error);
      end
      feed(2, 5, 0);
      in_op = 1'b0;
      Reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.Ram_WE, bus.Busy, bus.Delta_Ready} !== 3'b000) begin
         n_fail++; $display("FAIL abort_async: we/busy/rdy = %b, required 000", {bus.Ram_WE, bus.Busy, bus.Delta_Ready});
      end
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      @(posedge Clock); #1;
      bad = 0;
      for (int j = 0; j < 10; j++) if (mem[j] !== snap[j]) bad++;
      n_cmp++;
      if (we_cnt != w0 || bad != 0) begin
         n_fail++; $display("FAIL abort_no_write: we %0d, changed words %0d, required 0 0", we_cnt - w0, bad);
      end
      start_op(2'd0, 1'b1); feed(0, WORDS, 0); wait_done(lat);
      n_cmp++;
      if (wr_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++; $display("FAIL abort_resume_sb: writes %0d, expected %0d", wr_q.size(), exp_q.size());
      end else begin
         got = wr_q.pop_front(); exp = exp_q.pop_front();
         if (got !== exp) begin n_fail++; $display("FAIL abort_resume_sb: got %h, required %h", got, exp); end
      end
      bad = 0;
      for (int i = 0; i < WORDS; i++) if (mem[i] !== ((i % 2 == 0) ? 10'h2AB : 10'h156)) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL abort_resume_ram: %0d words wrong, word0=%h required 2ab", bad, mem[0]); end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, bad;
      wr_t got, exp;
      for (int k = 0; k < WORDS; k++) dl[k] = (k % 2 == 0) ? 10'h000 : 10'h1FF;
      start_op(2'd2, 1'b1); feed(0, WORDS, 0); wait_done(lat1);
      for (int k = 0; k < WORDS; k++) dl[k] = (k % 2 == 0) ? 10'h000 : 10'h201;
      start_op(2'd1, 1'b1);
      n_cmp++;
      if (bus.Busy !== 1'b1 || bus.Ram_Address !== 5'd10) begin
         n_fail++; $display("FAIL b2b_accept: busy %b addr %0d, required 1 10", bus.Busy, bus.Ram_Address);
      end
      feed(0, WORDS, 0); wait_done(lat2);
      n_cmp++;
      if (lat2 != 13) begin n_fail++; $display("FAIL b2b_latency: Done at edge %0d, required 13", lat2); end
      for (int n = 0; n < 2; n++) begin
         n_cmp++;
         if (wr_q.size() == 0 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL b2b_sb%0d: writes %0d, expected %0d", n, wr_q.size(), exp_q.size());
         end else begin
            got = wr_q.pop_front(); exp = exp_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL b2b_sb%0d: got %h, required %h", n, got, exp); end
         end
      end
      bad = 0;
      for (int i = 0; i < WORDS; i++) begin
         if (mem[20 + i] !== ((i % 2 == 0) ? 10'h200 : 10'h3FF)) bad++;
         if (mem[10 + i] !== ((i % 2 == 0) ? 10'h1FF : 10'h000)) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++; $display("FAIL b2b_ram: %0d words wrong, w20=%h w21=%h w10=%h w11=%h", bad, mem[20], mem[21], mem[10], mem[11]);
      end
      n_cmp++;
      if (rdy_bad != 0 || exp_q.size() != 0 || wr_q.size() != 0) begin
         n_fail++; $display("FAIL final_state: ready-outside-op %0d, leftover exp %0d writes %0d, required 0 0 0", rdy_bad, exp_q.size(), wr_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_valid_toggle();
      test_saturation();
      test_error();
      test_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
